// File: rtl/onn_pkg.sv
// ---------------------------------------------------------------------------
// onn_pkg
// Shared constants and types for the ONN run controller slice.
//   N_OSC       : oscillator count (pattern width)
//   LOAD_CYC    : cycles osc_load is held high
//   SETTLE_CYC  : cycles after load during which status flags are ignored
//   MAX_RUN     : RUN-state cycle limit before timeout
//   MAX_RETRY   : reloads allowed after an inconsistent indication
//   state_e     : controller state encoding (3 bits, 6 states)
// ---------------------------------------------------------------------------
package onn_pkg;

  localparam int N_OSC      = 15;
  localparam int LOAD_CYC   = 4;
  localparam int SETTLE_CYC = 128;
  localparam int MAX_RUN    = 100000;
  localparam int MAX_RETRY  = 3;

  localparam int RUNCNT_W   = 17;
  localparam int RETRY_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/onn_run_controller_if.sv
// ---------------------------------------------------------------------------
// onn_run_controller_if
// Bundles the host-side command/result signals and the oscillator-array /
// status-monitor signals of the run controller.
//   master : controller view (drives osc_*, busy, done, result fields)
//   slave  : host + array view (drives start, abort, pattern, status, state)
// ---------------------------------------------------------------------------
interface onn_run_controller_if;
  import onn_pkg::*;

  // host side
  logic                start;
  logic                abort;
  logic [N_OSC-1:0]    pattern_in;
  logic                busy;
  logic                done;
  logic [N_OSC-1:0]    result;
  logic                result_valid;
  logic                converged;
  logic                timeout;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [RUNCNT_W-1:0] run_cycles;

  // oscillator array / status monitor side
  logic                full_tick;
  logic                steady_cheak;
  logic                inconsistant_cheak;
  logic [N_OSC-1:0]    osc_state;
  logic                osc_load;
  logic [N_OSC-1:0]    osc_pattern;
  logic                osc_run;

  modport master (
    input  start, abort, pattern_in, full_tick, steady_cheak,
           inconsistant_cheak, osc_state,
    output osc_load, osc_pattern, osc_run, busy, done, result,
           result_valid, converged, timeout, retry_cnt, run_cycles
  );

  modport slave (
    output start, abort, pattern_in, full_tick, steady_cheak,
           inconsistant_cheak, osc_state,
    input  osc_load, osc_pattern, osc_run, busy, done, result,
           result_valid, converged, timeout, retry_cnt, run_cycles
  );

endinterface

// File: rtl/onn_phase_timer.sv
// ---------------------------------------------------------------------------
// onn_phase_timer
// Single down-counter timing the LOAD and SETTLE phases.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : (re)start the timer with load_val_i cycles
//   load_val_i  : phase length in cycles (>= 1)
//   expire_o    : high during the last cycle of the loaded phase
// ---------------------------------------------------------------------------
module onn_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic         active_q;

  // Counting from load_val-1 down to 0 makes expire fall on the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      count_q  <= load_val_i - W'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == '0) active_q <= 1'b0;
      else               count_q  <= count_q - W'(1);
    end
  end

  assign expire_o = active_q && (count_q == '0);

endmodule

// File: rtl/onn_run_controller.sv
// ---------------------------------------------------------------------------
// onn_run_controller
// Sequences one ONN inference run: load pattern, settle, run until the
// status monitor reports steady / inconsistent (with reloads) or a cycle
// limit is hit, then capture the oscillator state as the recalled pattern.
//   sclk, rst_n : system clock, async active-low reset
//   bus         : onn_run_controller_if.master (host + array signals)
// ---------------------------------------------------------------------------
module onn_run_controller
  import onn_pkg::*;
#(
  parameter int LOAD_CYC_P   = LOAD_CYC,
  parameter int SETTLE_CYC_P = SETTLE_CYC,
  parameter int MAX_RUN_P    = MAX_RUN,
  parameter int MAX_RETRY_P  = MAX_RETRY
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  onn_run_controller_if.master bus
);

  localparam int TW = $clog2((SETTLE_CYC_P > LOAD_CYC_P ? SETTLE_CYC_P : LOAD_CYC_P) + 1);

  state_e               state_q, state_d;
  logic [N_OSC-1:0]     pattern_q, result_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [RUNCNT_W-1:0]  run_cycles_q, run_cnt_inc;
  logic                 result_valid_q, converged_q, timeout_q;
  logic                 tmr_load, tmr_expire;
  logic [TW-1:0]        tmr_val;
  logic                 steady_hit, incons_hit, run_limit, start_acc;
  logic                 osc_load_c, osc_run_c, busy_c, done_c;

  // Status flags are only meaningful while full_tick is low.
  assign steady_hit  = !bus.full_tick && bus.steady_cheak;
  assign incons_hit  = !bus.full_tick && bus.inconsistant_cheak && !bus.steady_cheak;
  assign run_cnt_inc = (&run_cycles_q) ? run_cycles_q : run_cycles_q + RUNCNT_W'(1);
  assign run_limit   = (run_cnt_inc == RUNCNT_W'(MAX_RUN_P - 1));
  assign start_acc   = (state_q == ST_IDLE) && bus.start && !bus.abort;

  // Timer restarts on every entry into LOAD or SETTLE (including retries).
  assign tmr_load = (state_d != state_q) && (state_d == ST_LOAD || state_d == ST_SETTLE);
  assign tmr_val  = (state_d == ST_LOAD) ? TW'(LOAD_CYC_P) : TW'(SETTLE_CYC_P);

  onn_phase_timer #(.W(TW)) u_timer (
    .clk        (sclk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // State register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything, including start in IDLE
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.start) state_d = ST_LOAD;
        ST_LOAD:    if (tmr_expire) state_d = ST_SETTLE;
        ST_SETTLE:  if (tmr_expire) state_d = ST_RUN;
        ST_RUN: begin
          if (steady_hit)      state_d = ST_CAPTURE;
          else if (incons_hit) state_d = (retry_q < RETRY_W'(MAX_RETRY_P)) ? ST_LOAD : ST_CAPTURE;
          else if (run_limit)  state_d = ST_CAPTURE;
        end
        ST_CAPTURE: state_d = ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    osc_load_c = 1'b0;
    osc_run_c  = 1'b0;
    busy_c     = (state_q != ST_IDLE);
    done_c     = 1'b0;
    case (state_q)
      ST_LOAD:   osc_load_c = 1'b1;
      ST_SETTLE: osc_run_c  = 1'b1;
      ST_RUN:    osc_run_c  = 1'b1;
      ST_DONE:   done_c     = 1'b1;
      default:   ;
    endcase
  end

  // Run bookkeeping and result capture
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q      <= '0;
      result_q       <= '0;
      retry_q        <= '0;
      run_cycles_q   <= '0;
      result_valid_q <= 1'b0;
      converged_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      if (start_acc) begin
        pattern_q      <= bus.pattern_in;
        retry_q        <= '0;
        result_valid_q <= 1'b0;
        converged_q    <= 1'b0;
        timeout_q      <= 1'b0;
      end
      if (bus.abort && state_q != ST_IDLE) result_valid_q <= 1'b0;
      if (state_d == ST_LOAD && state_q != ST_LOAD) run_cycles_q <= '0;
      if (state_q == ST_RUN && (state_d == ST_RUN || state_d == ST_CAPTURE))
        run_cycles_q <= run_cnt_inc;
      if (state_q == ST_RUN && state_d == ST_LOAD) retry_q <= retry_q + RETRY_W'(1);
      if (state_q == ST_RUN && state_d == ST_CAPTURE) begin
        converged_q <= steady_hit;
        timeout_q   <= !steady_hit && !incons_hit;
      end
      if (state_q == ST_CAPTURE && state_d == ST_DONE) result_q <= bus.osc_state;
      if (state_d == ST_DONE) result_valid_q <= 1'b1;
    end
  end

  assign bus.osc_load     = osc_load_c;
  assign bus.osc_run      = osc_run_c;
  assign bus.osc_pattern  = pattern_q;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.converged    = converged_q;
  assign bus.timeout      = timeout_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_onn_run_controller.sv
// ---------------------------------------------------------------------------
// tb_onn_run_controller
// Scoreboard bench: each run pushes its hand-computed outcome into exp_q;
// the monitor pops and compares on every done pulse.
// MAX_RUN is reduced to 400 so the timeout run stays short.
// ---------------------------------------------------------------------------
module tb_onn_run_controller;
  import onn_pkg::*;

  localparam int TB_MAX_RUN = 400;
  localparam int SC = SETTLE_CYC;
  localparam int F_NONE = 0, F_STEADY = 1, F_INC = 2, F_END = 3;

  typedef struct {
    logic [14:0] res;
    logic        conv;
    logic        to;
    logic [1:0]  retry;
    logic [16:0] rc;
    int          lat;    // inclusive cycles from start cycle to done cycle
    int          loads;  // LOAD phases in the run
  } exp_t;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  onn_run_controller_if bus();

  onn_run_controller #(.MAX_RUN_P(TB_MAX_RUN)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [14:0] res, input logic conv, input logic to,
                              input logic [1:0] retry, input logic [16:0] rc,
                              input int lat, input int loads);
    exp_t e;
    e.res = res; e.conv = conv; e.to = to; e.retry = retry;
    e.rc = rc; e.lat = lat; e.loads = loads;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int   lat_cnt = 0, load_cnt = 0;
  logic busy_prev = 1'b0, load_prev = 1'b0;
  exp_t me;

  always @(negedge sclk) begin
    if (!rst_n) begin
      lat_cnt = 0; load_cnt = 0; busy_prev = 1'b0; load_prev = 1'b0;
    end else begin
      if (bus.busy && !busy_prev) begin lat_cnt = 2; load_cnt = 0; end
      else if (bus.busy) lat_cnt++;
      if (bus.osc_load && !load_prev) load_cnt++;
      busy_prev = bus.busy;
      load_prev = bus.osc_load;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
        end else begin
          me = exp_q.pop_front();
          chk("result",       32'(bus.result),     32'(me.res));
          chk("converged",    32'(bus.converged),  32'(me.conv));
          chk("timeout",      32'(bus.timeout),    32'(me.to));
          chk("retry_cnt",    32'(bus.retry_cnt),  32'(me.retry));
          chk("run_cycles",   32'(bus.run_cycles), 32'(me.rc));
          chk("result_valid", 32'(bus.result_valid), 32'd1);
          chk("latency",      32'(lat_cnt),        32'(me.lat));
          chk("load_phases",  32'(load_cnt),       32'(me.loads));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic clr_status();
    bus.full_tick = 1'b0; bus.steady_cheak = 1'b0; bus.inconsistant_cheak = 1'b0;
  endtask

  // One load/settle/run attempt; flag is presented on RUN cycle k.
  task automatic attempt(input int flag, input int k, input bit noise, input logic [14:0] pat);
    int guard = 0;
    while (!bus.osc_run && guard < 2000) begin @(negedge sclk); guard++; end
    chk("settle_reached", 32'(guard < 2000), 32'd1);
    for (int rc = 1; rc <= SC + k; rc++) begin
      bus.start      = (rc == 3);   // start while busy must be ignored
      bus.pattern_in = ~pat;
      if (rc == SC) chk("pattern_hold", 32'(bus.osc_pattern), 32'(pat));
      if (rc == SC + k) begin
        bus.full_tick = 1'b0;
        bus.steady_cheak = (flag == F_STEADY);
        bus.inconsistant_cheak = (flag == F_INC);
      end else if (noise) begin
        bus.full_tick = (rc > SC);  // SETTLE: valid-looking flags; RUN: masked flags
        bus.steady_cheak = 1'b1;
        bus.inconsistant_cheak = 1'b1;
      end else begin
        clr_status();
      end
      @(negedge sclk);
    end
    bus.start = 1'b0;
    clr_status();
  endtask

  task automatic do_run(input logic [14:0] pat, input logic [14:0] st, input int k,
                        input int n_inc, input int fin, input bit noise, input exp_t e);
    int guard = 0;
    exp_q.push_back(e);
    @(negedge sclk);
    bus.pattern_in = pat; bus.osc_state = st; bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    for (int i = 0; i < n_inc; i++) attempt(F_INC, k, noise, pat);
    if (fin != F_END) attempt(fin, k, noise, pat);
    while (bus.busy && guard < 50) begin @(negedge sclk); guard++; end
    chk("run_finished", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge sclk);
  endtask

  task automatic start_and_reach_run(input logic [14:0] pat);
    int guard = 0;
    @(negedge sclk);
    bus.pattern_in = pat; bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    while (!bus.osc_run && guard < 2000) begin @(negedge sclk); guard++; end
    repeat (SC + 5) @(negedge sclk);
    chk("in_run", 32'(bus.osc_run), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     32'(bus.busy), 0);
    chk({tag, "_osc_load"}, 32'(bus.osc_load), 0);
    chk({tag, "_osc_run"},  32'(bus.osc_run), 0);
    chk({tag, "_done"},     32'(bus.done), 0);
    chk({tag, "_pattern"},  32'(bus.osc_pattern), 0);
    chk({tag, "_result"},   32'(bus.result), 0);
    chk({tag, "_rvalid"},   32'(bus.result_valid), 0);
    chk({tag, "_conv"},     32'(bus.converged), 0);
    chk({tag, "_timeout"},  32'(bus.timeout), 0);
    chk({tag, "_retry"},    32'(bus.retry_cnt), 0);
    chk({tag, "_runcyc"},   32'(bus.run_cycles), 0);
  endtask

  initial begin
    int guard;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern_in = '0; bus.osc_state = '0;
    clr_status();
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    // pattern, osc_state, k, inconsistents, final, noise, expected outcome
    do_run(15'h01A5, 15'h2B3C, 40,  0, F_STEADY, 1'b0, mk(15'h2B3C, 1, 0, 0, 40,  175, 1));
    do_run(15'h0F0F, 15'h1234, 10,  3, F_STEADY, 1'b0, mk(15'h1234, 1, 0, 3, 10,  571, 4));
    do_run(15'h7001, 15'h4321, 10,  4, F_END,    1'b0, mk(15'h4321, 0, 0, 3, 10,  571, 4));
    do_run(15'h5555, 15'h0AAA, 25,  0, F_STEADY, 1'b1, mk(15'h0AAA, 1, 0, 0, 25,  160, 1));
    do_run(15'h0001, 15'h7FFE, 399, 0, F_NONE,   1'b0, mk(15'h7FFE, 0, 1, 0, 399, 534, 1));
    do_run(15'h4000, 15'h3333, 399, 0, F_STEADY, 1'b0, mk(15'h3333, 1, 0, 0, 399, 534, 1));

    // abort in RUN: back to IDLE next cycle, previous result kept
    start_and_reach_run(15'h0707);
    bus.abort = 1'b1;
    @(negedge sclk);
    bus.abort = 1'b0;
    chk("abort_busy",    32'(bus.busy), 0);
    chk("abort_osc_run", 32'(bus.osc_run), 0);
    chk("abort_rvalid",  32'(bus.result_valid), 0);
    chk("abort_result",  32'(bus.result), 32'h3333);
    repeat (10) @(negedge sclk);

    // abort with start in IDLE: start not accepted
    bus.pattern_in = 15'h0123; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_start_busy",    32'(bus.busy), 0);
    chk("abort_start_pattern", 32'(bus.osc_pattern), 32'h0707);
    repeat (3) @(negedge sclk);

    // async reset mid-RUN, between clock edges
    start_and_reach_run(15'h0606);
    @(posedge sclk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);
    do_run(15'h03C3, 15'h1111, 5, 0, F_STEADY, 1'b0, mk(15'h1111, 1, 0, 0, 5, 140, 1));

    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin @(negedge sclk); guard++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
